// File: rtl/prm_edge_scan_ctrl.sv
// rtl/prm_edge_scan_ctrl.sv - PRM edge scan sequencer driving the shared obstacle-checker bank
// Optional build macro PRM_EARLY_ABORT_EN: finish an edge at its first colliding sample.
module prm_edge_scan_ctrl #(
    parameter int CFG_W   = 15,
    parameter int NUM_CHK = 32,
    parameter int EDGE_W  = 12,
    parameter int SMP_W   = 4,
    parameter int CHK_LAT = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [EDGE_W-1:0]  num_edges_i,
    input  logic [SMP_W-1:0]   smp_per_edge_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               smp_req_o,
    output logic [EDGE_W-1:0]  smp_edge_o,
    output logic [SMP_W-1:0]   smp_idx_o,
    input  logic               smp_vld_i,
    input  logic [CFG_W-1:0]   smp_cfg_i,
    output logic [CFG_W-1:0]   chk_cfg_o,
    input  logic [NUM_CHK-1:0] chk_mask_i,
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic [EDGE_W-1:0]  res_edge_o,
    output logic               res_blocked_o,
    output logic [NUM_CHK-1:0] res_hits_o
);

    localparam int LAT_W = (CHK_LAT > 1) ? $clog2(CHK_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_ACC    = 3'd3,
        S_REPORT = 3'd4,
        S_FIN    = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [EDGE_W-1:0]   num_edges_q, num_edges_d;
    logic [SMP_W-1:0]    eff_smp_q, eff_smp_d;
    logic [EDGE_W-1:0]   edge_q, edge_d;
    logic [SMP_W-1:0]    idx_q, idx_d;
    logic [NUM_CHK-1:0]  hits_q, hits_d;
    logic [CFG_W-1:0]    cfg_q, cfg_d;
    logic [LAT_W-1:0]    lat_q, lat_d;

    logic [NUM_CHK-1:0]  hits_acc;
    logic                last_smp;
    logic                last_edge;
    logic                early_abort;

    assign hits_acc  = hits_q | chk_mask_i;
    assign last_smp  = (idx_q == eff_smp_q - SMP_W'(1));
    assign last_edge = (edge_q == num_edges_q - EDGE_W'(1));

`ifdef PRM_EARLY_ABORT_EN
    assign early_abort = |hits_acc;
`else
    assign early_abort = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            num_edges_q <= '0;
            eff_smp_q   <= '0;
            edge_q      <= '0;
            idx_q       <= '0;
            hits_q      <= '0;
            cfg_q       <= '0;
            lat_q       <= '0;
        end else begin
            state_q     <= state_d;
            num_edges_q <= num_edges_d;
            eff_smp_q   <= eff_smp_d;
            edge_q      <= edge_d;
            idx_q       <= idx_d;
            hits_q      <= hits_d;
            cfg_q       <= cfg_d;
            lat_q       <= lat_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        num_edges_d = num_edges_q;
        eff_smp_d   = eff_smp_q;
        edge_d      = edge_q;
        idx_d       = idx_q;
        hits_d      = hits_q;
        cfg_d       = cfg_q;
        lat_d       = lat_q;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        smp_req_o   = 1'b0;
        res_valid_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    num_edges_d = num_edges_i;
                    // A zero sample count still checks the edge once.
                    eff_smp_d   = (smp_per_edge_i == '0) ? SMP_W'(1) : smp_per_edge_i;
                    edge_d      = '0;
                    idx_d       = '0;
                    hits_d      = '0;
                    state_d     = (num_edges_i == '0) ? S_FIN : S_FETCH;
                end
            end
            S_FETCH: begin
                busy_o    = 1'b1;
                smp_req_o = 1'b1;
                if (smp_vld_i) begin
                    cfg_d   = smp_cfg_i;
                    lat_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                busy_o = 1'b1;
                if (lat_q == LAT_W'(CHK_LAT - 1)) begin
                    state_d = S_ACC;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            S_ACC: begin
                busy_o = 1'b1;
                hits_d = hits_acc;
                if (last_smp || early_abort) begin
                    state_d = S_REPORT;
                end else begin
                    idx_d   = idx_q + SMP_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_REPORT: begin
                busy_o      = 1'b1;
                res_valid_o = 1'b1;
                if (res_ready_i) begin
                    hits_d  = '0;
                    idx_d   = '0;
                    edge_d  = edge_q + EDGE_W'(1);
                    state_d = last_edge ? S_FIN : S_FETCH;
                end
            end
            S_FIN: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign smp_edge_o    = edge_q;
    assign smp_idx_o     = idx_q;
    assign chk_cfg_o     = cfg_q;
    assign res_edge_o    = edge_q;
    assign res_hits_o    = hits_q;
    assign res_blocked_o = |hits_q;

endmodule

// File: tb/tb_prm_edge_scan_ctrl.sv
// tb/tb_prm_edge_scan_ctrl.sv - self-checking bench for prm_edge_scan_ctrl
module tb_prm_edge_scan_ctrl;

    localparam int CFG_W   = 15;
    localparam int NUM_CHK = 32;
    localparam int EDGE_W  = 12;
    localparam int SMP_W   = 4;

    logic               clk = 1'b0;
    logic               rst_i = 1'b1;
    logic               start_i = 1'b0;
    logic [EDGE_W-1:0]  num_edges_i = '0;
    logic [SMP_W-1:0]   smp_per_edge_i = '0;
    logic               busy_o, done_o, smp_req_o;
    logic [EDGE_W-1:0]  smp_edge_o;
    logic [SMP_W-1:0]   smp_idx_o;
    logic               smp_vld_i = 1'b0;
    logic [CFG_W-1:0]   smp_cfg_i = '0;
    logic [CFG_W-1:0]   chk_cfg_o;
    logic [NUM_CHK-1:0] chk_mask_i = '0;
    logic               res_valid_o;
    logic               res_ready_i = 1'b0;
    logic [EDGE_W-1:0]  res_edge_o;
    logic               res_blocked_o;
    logic [NUM_CHK-1:0] res_hits_o;

    always #5 clk = ~clk;

    prm_edge_scan_ctrl #(
        .CFG_W(CFG_W), .NUM_CHK(NUM_CHK), .EDGE_W(EDGE_W), .SMP_W(SMP_W), .CHK_LAT(1)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .num_edges_i(num_edges_i), .smp_per_edge_i(smp_per_edge_i),
        .busy_o(busy_o), .done_o(done_o), .smp_req_o(smp_req_o),
        .smp_edge_o(smp_edge_o), .smp_idx_o(smp_idx_o),
        .smp_vld_i(smp_vld_i), .smp_cfg_i(smp_cfg_i),
        .chk_cfg_o(chk_cfg_o), .chk_mask_i(chk_mask_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_edge_o(res_edge_o), .res_blocked_o(res_blocked_o), .res_hits_o(res_hits_o)
    );

    typedef struct {
        int          ne;
        int          spe;
        int          he0, hi0;
        logic [31:0] hv0;
        int          he1, hi1;
        logic [31:0] hv1;
        int          gap;
        int          stall_edge;
        bit          stray;
        int          exp_fetch;
        int          exp_res;
    } vec_t;

    typedef struct { int e; int i; } fetch_t;
    typedef struct { int e; logic [31:0] hits; } res_t;

    vec_t             vecs[6];
    logic [31:0]      hit_map [0:7][0:15];
    fetch_t           fq[$];
    res_t             rq[$];
    logic [CFG_W-1:0] cfg_prev = '0;
    int               n_cmp = 0;
    int               n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CFG_W-1:0] enc(input int e, input int i);
        logic [10:0] ee;
        logic [3:0]  ii;
        ee = 11'(e);
        ii = 4'(i);
        return {ee, ii};
    endfunction

    function automatic logic [31:0] mask_of(input logic [CFG_W-1:0] cfg);
        int e;
        e = int'(cfg[14:4]);
        if (e < 8) return hit_map[e][cfg[3:0]];
        return 32'h0;
    endfunction

    // Checker bank model: mask reflects the config seen one cycle earlier.
    task automatic tick();
        @(negedge clk);
        chk_mask_i = mask_of(cfg_prev);
        cfg_prev   = chk_cfg_o;
    endtask

    function automatic vec_t mk(input int ne, input int spe,
                                input int he0, input int hi0, input logic [31:0] hv0,
                                input int he1, input int hi1, input logic [31:0] hv1,
                                input int gap, input int stall_edge, input bit stray,
                                input int exp_fetch, input int exp_res);
        vec_t v;
        v.ne = ne; v.spe = spe;
        v.he0 = he0; v.hi0 = hi0; v.hv0 = hv0;
        v.he1 = he1; v.hi1 = hi1; v.hv1 = hv1;
        v.gap = gap; v.stall_edge = stall_edge; v.stray = stray;
        v.exp_fetch = exp_fetch; v.exp_res = exp_res;
        return v;
    endfunction

    task automatic build_model(input vec_t v);
        logic [31:0] acc;
        int          eff;
        for (int e = 0; e < 8; e++)
            for (int i = 0; i < 16; i++) hit_map[e][i] = 32'h0;
        if (v.hv0 != 0) hit_map[v.he0][v.hi0] = v.hv0;
        if (v.hv1 != 0) hit_map[v.he1][v.hi1] = v.hv1;
        fq.delete();
        rq.delete();
        eff = (v.spe == 0) ? 1 : v.spe;
        for (int e = 0; e < v.ne; e++) begin
            acc = 32'h0;
            for (int i = 0; i < eff; i++) begin
                fq.push_back('{e, i});
                acc |= hit_map[e][i];
`ifdef PRM_EARLY_ABORT_EN
                if (acc != 0) break;
`endif
            end
            rq.push_back('{e, acc});
        end
    endtask

    task automatic run_scan(input vec_t v, input string tag);
        int               fetches = 0, results = 0, gap_cnt = 0, stall_cnt = 0, cyc = 0;
        bit               stalled = 0, finished = 0;
        logic [EDGE_W-1:0] st_edge = '0;
        logic [31:0]      st_hits = '0;
        logic [CFG_W-1:0] last_cfg = '0;
        fetch_t           f;
        res_t             r;
        build_model(v);
        tick();
        num_edges_i = EDGE_W'(v.ne);
        smp_per_edge_i = SMP_W'(v.spe);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        num_edges_i = '0;
        smp_per_edge_i = '0;
        while (!finished && cyc < 2000) begin
            smp_vld_i = 1'b0;
            res_ready_i = 1'b0;
            if (done_o) begin
                finished = 1;
                chk({tag, " busy low with done"}, 64'(busy_o), 64'd0);
                if (v.ne == 0) chk({tag, " zero-edge done latency"}, 64'(cyc), 64'd0);
            end else begin
                if (smp_req_o) begin
                    if (gap_cnt < v.gap) begin
                        gap_cnt++;
                    end else begin
                        gap_cnt = 0;
                        smp_vld_i = 1'b1;
                        smp_cfg_i = enc(int'(smp_edge_o), int'(smp_idx_o));
                        last_cfg = smp_cfg_i;
                        fetches++;
                        if (fq.size() == 0) begin
                            chk({tag, " unexpected fetch"}, {smp_edge_o, smp_idx_o}, 64'hFFFF_FFFF);
                        end else begin
                            f = fq.pop_front();
                            chk({tag, " fetch edge/idx"}, {smp_edge_o, smp_idx_o}, 64'(f.e * 16 + f.i));
                        end
                    end
                end else if (v.stray && cyc[0]) begin
                    smp_vld_i = 1'b1;
                    smp_cfg_i = '1;
                end
                if (res_valid_o) begin
                    if (v.stall_edge >= 0 && int'(res_edge_o) == v.stall_edge && !stalled) begin
                        if (stall_cnt == 0) begin
                            st_edge = res_edge_o;
                            st_hits = res_hits_o;
                        end else begin
                            chk({tag, " stall hold"}, {res_valid_o, smp_req_o, res_edge_o, res_hits_o},
                                {1'b1, 1'b0, st_edge, st_hits});
                        end
                        stall_cnt++;
                        if (stall_cnt == 10) stalled = 1;
                    end else begin
                        res_ready_i = 1'b1;
                        results++;
                        if (rq.size() == 0) begin
                            chk({tag, " unexpected result"}, 64'(res_edge_o), 64'hFFFF_FFFF);
                        end else begin
                            r = rq.pop_front();
                            chk({tag, " result edge/hits/blocked"}, {res_edge_o, res_hits_o, res_blocked_o},
                                {EDGE_W'(r.e), r.hits, |r.hits});
                        end
                    end
                end
            end
            cyc++;
            if (!finished) tick();
        end
        if (!finished) chk({tag, " done timeout"}, 64'd0, 64'd1);
        smp_vld_i = 1'b0;
        res_ready_i = 1'b0;
        tick();
        chk({tag, " done single pulse, idle"}, {done_o, busy_o, smp_req_o, res_valid_o}, 64'd0);
        chk({tag, " fetch count"}, 64'(fetches), 64'(v.exp_fetch));
        chk({tag, " result count"}, 64'(results), 64'(v.exp_res));
        if (v.exp_fetch > 0) chk({tag, " chk_cfg holds last sample"}, 64'(chk_cfg_o), 64'(last_cfg));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " ctrl outputs zero"},
            {busy_o, done_o, smp_req_o, res_valid_o, res_blocked_o, smp_edge_o, smp_idx_o, res_edge_o}, 64'd0);
        chk({tag, " data outputs zero"}, {chk_cfg_o, res_hits_o}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit5;
        bit saw_done;
        vecs[0] = mk(0, 4, 0, 0, 32'h0, 0, 0, 32'h0, 0, -1, 0, 0, 0);
        vecs[1] = mk(3, 4, 0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 0, 12, 3);
`ifdef PRM_EARLY_ABORT_EN
        vecs[2] = mk(1, 4, 0, 2, 32'h0000_0100, 0, 0, 32'h0, 0, -1, 0, 3, 1);
        vecs[4] = mk(4, 3, 1, 0, 32'h1, 3, 2, 32'h8000_0000, 2, -1, 0, 10, 4);
        vecs[5] = mk(2, 2, 0, 0, 32'h3, 0, 1, 32'h4, 0, -1, 0, 3, 2);
`else
        vecs[2] = mk(1, 4, 0, 2, 32'h0000_0100, 0, 0, 32'h0, 0, -1, 0, 4, 1);
        vecs[4] = mk(4, 3, 1, 0, 32'h1, 3, 2, 32'h8000_0000, 2, -1, 0, 12, 4);
        vecs[5] = mk(2, 2, 0, 0, 32'h3, 0, 1, 32'h4, 0, -1, 0, 4, 2);
`endif
        vecs[3] = mk(2, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, -1, 1, 2, 2);

        rst_i = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rst_i = 1'b0;

        for (int k = 0; k < 6; k++) run_scan(vecs[k], $sformatf("vec%0d", k));

        // Reset while waiting on the checker for edge 5.
        tick();
        num_edges_i = 12'd8;
        smp_per_edge_i = 4'd2;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        hit5 = 0;
        saw_done = 0;
        for (int c = 0; c < 500 && !hit5; c++) begin
            smp_vld_i = 1'b0;
            res_ready_i = 1'b1;
            if (done_o) saw_done = 1;
            if (smp_req_o) begin
                smp_vld_i = 1'b1;
                smp_cfg_i = enc(int'(smp_edge_o), int'(smp_idx_o));
                if (smp_edge_o == 12'd5) begin
                    tick();
                    smp_vld_i = 1'b0;
                    chk("mid-scan in WAIT of edge5", {busy_o, smp_req_o, res_valid_o, smp_edge_o}, {3'b100, 12'd5});
                    rst_i = 1'b1;
                    hit5 = 1;
                end
            end
            tick();
        end
        chk("reached edge5 wait", 64'(hit5), 64'd1);
        chk("no done before abort", 64'(saw_done), 64'd0);
        check_all_zero("mid-scan reset");
        rst_i = 1'b0;
        res_ready_i = 1'b0;
        tick();
        chk("idle after reset release", {busy_o, done_o, smp_req_o, res_valid_o}, 64'd0);
        run_scan(vecs[1], "post-reset rescan");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
